// File: rtl/reg_serializer.sv
// rtl/reg_serializer.sv - captures an N-bit word on Load and streams it LSB first over a valid/ready serial link
// Optional feature macro: PARITY_EN (appends one even-parity beat after the data bits)
module reg_serializer #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         CLR,
   input  logic [N-1:0] DataIn,
   input  logic         Load,
   input  logic         SerReady,
   output logic         SerOut,
   output logic         SerValid,
   output logic         Busy,
   output logic         Done
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

`ifdef PARITY_EN
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2,
      PAR   = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;
`endif

   state_t         state;
   logic [N-1:0]   shiftReg;
   logic [CW-1:0]  bitCount;
   logic           serValidQ;
   logic           busyQ;
   logic           doneQ;
`ifdef PARITY_EN
   logic           parBit;
`endif

   // The serial bit is always shiftReg[0]: the register is zero outside a word,
   // and the parity bit is loaded into bit 0 for the parity beat.
   assign SerOut   = shiftReg[0];
   assign SerValid = serValidQ;
   assign Busy     = busyQ;
   assign Done     = doneQ;

   // Serializer FSM: capture in IDLE, one bit per accepted beat, single-cycle Done pulse.
   always_ff @(posedge clk) begin
      if (CLR) begin
         state     <= IDLE;
         shiftReg  <= '0;
         bitCount  <= '0;
         serValidQ <= 1'b0;
         busyQ     <= 1'b0;
         doneQ     <= 1'b0;
`ifdef PARITY_EN
         parBit    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (Load) begin
                  shiftReg  <= DataIn;
                  bitCount  <= '0;
`ifdef PARITY_EN
                  parBit    <= ^DataIn;
`endif
                  serValidQ <= 1'b1;
                  busyQ     <= 1'b1;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               if (SerReady) begin
                  if (bitCount == LAST_BIT) begin
                     // Count stops at N-1 instead of wrapping.
`ifdef PARITY_EN
                     shiftReg <= {{(N-1){1'b0}}, parBit};
                     state    <= PAR;
`else
                     shiftReg  <= '0;
                     serValidQ <= 1'b0;
                     doneQ     <= 1'b1;
                     state     <= DONE;
`endif
                  end else begin
                     shiftReg <= shiftReg >> 1;
                     bitCount <= bitCount + 1'b1;
                  end
               end
            end
`ifdef PARITY_EN
            PAR: begin
               if (SerReady) begin
                  shiftReg  <= '0;
                  serValidQ <= 1'b0;
                  doneQ     <= 1'b1;
                  state     <= DONE;
               end
            end
`endif
            DONE: begin
               // Load is ignored here; the next word is taken from IDLE.
               doneQ <= 1'b0;
               busyQ <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
